// File: rtl/pwm_gen_pkg.sv
// rtl/pwm_gen_pkg.sv - shared types, defaults and helpers for the multi-channel PWM generator
//
// Purpose: mode/direction encodings, default parameter values and the
// channel slice offset used to index the packed per-channel duty bus.
// Ports: none (package).

package pwm_gen_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_DIV_W  = 8;

    // Duty fields are CNT_W+1 bits wide so a compare value of period+1
    // (100% duty) is representable.
    function automatic int ch_offset(input int k, input int cnt_w);
        return k * (cnt_w + 1);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// rtl/pwm_timebase.sv - shared prescaler, up/down period counter and period boundary generation
//
// Purpose: produces the count value all channels compare against, the
// combinational boundary strobe used to apply shadow config, and a
// registered period_tick aligned with the first output of each period.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          run when 1; counters held at 0 when 0
//   prescale        one count tick every prescale+1 clocks
//   period          counter top value
//   center          0 = edge-aligned, 1 = center-aligned
//   apply           shadow config is being applied this cycle (forces dir up)
//   cnt             current count
//   boundary        high on the tick that ends a period
//   period_tick     boundary delayed to line up with the registered outputs

module pwm_timebase
    import pwm_gen_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [DIV_W-1:0] prescale,
    input  logic [CNT_W-1:0] period,
    input  logic             center,
    input  logic             apply,
    output logic [CNT_W-1:0] cnt,
    output logic             boundary,
    output logic             period_tick
);

    logic [DIV_W-1:0] presc_cnt;
    pwm_dir_e         dir;
    logic             tick;
    logic             bnd_q;

    // >= rather than == so a freshly applied smaller prescale or period can
    // never leave the counters stranded above their new limit.
    assign tick = enable && (presc_cnt >= prescale);

    always_comb begin
        boundary = 1'b0;
        if (tick) begin
            if (period == '0) begin
                boundary = 1'b1;
            end else if (center == PWM_CENTER) begin
                boundary = (dir == DIR_DOWN) && (cnt == '0);
            end else begin
                boundary = (cnt >= period);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt   <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            bnd_q       <= 1'b0;
            period_tick <= 1'b0;
        end else if (!enable) begin
            presc_cnt   <= '0;
            cnt         <= '0;
            dir         <= DIR_UP;
            bnd_q       <= 1'b0;
            period_tick <= 1'b0;
        end else begin
            // Two stages: cnt is one clock behind boundary, pwm_out one
            // clock behind cnt, so period_tick needs two.
            bnd_q       <= boundary;
            period_tick <= bnd_q;
            if (tick) begin
                presc_cnt <= '0;
                if (period == '0) begin
                    cnt <= '0;
                    dir <= DIR_UP;
                end else if (center == PWM_CENTER) begin
                    if (dir == DIR_UP) begin
                        if (cnt >= period) begin
                            dir <= DIR_DOWN;
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end else begin
                        if (cnt == '0) begin
                            dir <= DIR_UP;
                            cnt <= cnt + 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end else begin
                    cnt <= (cnt >= period) ? '0 : cnt + 1'b1;
                    dir <= DIR_UP;
                end
                // A mode change lands here; always restart center counting upward.
                if (apply) begin
                    dir <= DIR_UP;
                end
            end else begin
                presc_cnt <= presc_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_gen_multi.sv
// rtl/pwm_gen_multi.sv - multi-channel PWM generator with shadowed configuration
//
// Purpose: N PWM channels sharing one time base; configuration is captured
// into shadow registers by cfg_load and copied to the active set at a
// period boundary (or immediately while disabled).
// Ports:
//   pwm_clk, rst     clock, synchronous active-high reset
//   enable           run when 1; outputs idle at polarity level when 0
//   cfg_load         one-cycle pulse capturing all cfg_* into the shadow
//   cfg_prescale     prescaler compare
//   cfg_period       counter top value
//   cfg_center       0 = edge-aligned, 1 = center-aligned
//   cfg_duty         per-channel compare, channel k at [k*(CNT_W+1) +: CNT_W+1]
//   cfg_pol          per-channel output inversion
//   cfg_pending      shadow holds values not yet applied
//   period_tick      one-cycle pulse with the first output of each period
//   pwm_out          registered PWM outputs

module pwm_gen_multi
    import pwm_gen_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic                      pwm_clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      cfg_load,
    input  logic [DIV_W-1:0]          cfg_prescale,
    input  logic [CNT_W-1:0]          cfg_period,
    input  logic                      cfg_center,
    input  logic [NUM_CH*(CNT_W+1)-1:0] cfg_duty,
    input  logic [NUM_CH-1:0]         cfg_pol,
    output logic                      cfg_pending,
    output logic                      period_tick,
    output logic [NUM_CH-1:0]         pwm_out
);

    localparam int DUTY_W = CNT_W + 1;

    logic [DIV_W-1:0]           sh_prescale,  act_prescale;
    logic [CNT_W-1:0]           sh_period,    act_period;
    logic                       sh_center,    act_center;
    logic [NUM_CH*DUTY_W-1:0]   sh_duty,      act_duty;
    logic [NUM_CH-1:0]          sh_pol,       act_pol;

    logic [CNT_W-1:0]  cnt;
    logic              boundary;
    logic              apply;
    logic              bypass;
    logic [NUM_CH-1:0] raw;

    // boundary is never asserted while disabled, so the disabled path
    // applies any pending shadow every cycle.
    assign apply  = cfg_pending && (boundary || !enable);
    // While disabled there is no period to protect: a load goes straight
    // to the active set as well as the shadow.
    assign bypass = cfg_load && !enable;

    pwm_timebase #(
        .CNT_W (CNT_W),
        .DIV_W (DIV_W)
    ) u_timebase (
        .clk         (pwm_clk),
        .rst         (rst),
        .enable      (enable),
        .prescale    (act_prescale),
        .period      (act_period),
        .center      (act_center),
        .apply       (apply),
        .cnt         (cnt),
        .boundary    (boundary),
        .period_tick (period_tick)
    );

    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            sh_prescale  <= '0;
            sh_period    <= '0;
            sh_center    <= 1'b0;
            sh_duty      <= '0;
            sh_pol       <= '0;
            act_prescale <= '0;
            act_period   <= '0;
            act_center   <= 1'b0;
            act_duty     <= '0;
            act_pol      <= '0;
            cfg_pending  <= 1'b0;
        end else begin
            if (bypass) begin
                act_prescale <= cfg_prescale;
                act_period   <= cfg_period;
                act_center   <= cfg_center;
                act_duty     <= cfg_duty;
                act_pol      <= cfg_pol;
            end else if (apply) begin
                act_prescale <= sh_prescale;
                act_period   <= sh_period;
                act_center   <= sh_center;
                act_duty     <= sh_duty;
                act_pol      <= sh_pol;
            end

            // A load on the boundary cycle: old shadow goes active above,
            // new values wait here for the next boundary.
            if (cfg_load) begin
                sh_prescale <= cfg_prescale;
                sh_period   <= cfg_period;
                sh_center   <= cfg_center;
                sh_duty     <= cfg_duty;
                sh_pol      <= cfg_pol;
                cfg_pending <= enable;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic [DUTY_W-1:0] duty_k;
        assign duty_k = act_duty[ch_offset(k, CNT_W) +: DUTY_W];
        // Zero-extended compare: duty 0 never fires, duty > period always does.
        assign raw[k] = ({1'b0, cnt} < duty_k);
    end

    always_ff @(posedge pwm_clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else if (!enable) begin
            pwm_out <= act_pol;
        end else begin
            pwm_out <= raw ^ act_pol;
        end
    end

endmodule

// File: tb/tb_pwm_gen_multi.sv
// tb/tb_pwm_gen_multi.sv - directed self-checking bench for pwm_gen_multi

module tb_pwm_gen_multi;

    logic        pwm_clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        cfg_load;
    logic [7:0]  cfg_prescale;
    logic [7:0]  cfg_period;
    logic        cfg_center;
    logic [35:0] cfg_duty;
    logic [3:0]  cfg_pol;
    logic        cfg_pending;
    logic        period_tick;
    logic [3:0]  pwm_out;

    int checks = 0;
    int errors = 0;

    logic [3:0][31:0] pw;
    logic [31:0]      tk;
    logic [31:0]      pw5;

    always #5 pwm_clk = ~pwm_clk;

    pwm_gen_multi #(
        .NUM_CH (4),
        .CNT_W  (8),
        .DIV_W  (8)
    ) dut (
        .pwm_clk      (pwm_clk),
        .rst          (rst),
        .enable       (enable),
        .cfg_load     (cfg_load),
        .cfg_prescale (cfg_prescale),
        .cfg_period   (cfg_period),
        .cfg_center   (cfg_center),
        .cfg_duty     (cfg_duty),
        .cfg_pol      (cfg_pol),
        .cfg_pending  (cfg_pending),
        .period_tick  (period_tick),
        .pwm_out      (pwm_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] duties(input logic [8:0] d3, input logic [8:0] d2,
                                           input logic [8:0] d1, input logic [8:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    task automatic load_cfg(input logic [7:0] presc, input logic [7:0] per, input logic ctr,
                            input logic [35:0] duty, input logic [3:0] pol);
        cfg_prescale = presc;
        cfg_period   = per;
        cfg_center   = ctr;
        cfg_duty     = duty;
        cfg_pol      = pol;
        cfg_load     = 1'b1;
        @(negedge pwm_clk);
        cfg_load     = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (period_tick !== 1'b1 && n < 400) begin
            @(negedge pwm_clk);
            n++;
        end
        check_eq({tag, "_sync"}, 32'(period_tick), 32'd1);
    endtask

    // Sample n cycles starting at the current negedge; bit i is cycle i.
    task automatic capture(input int n, output logic [3:0][31:0] p, output logic [31:0] t);
        p = '0;
        t = '0;
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) p[c][i] = pwm_out[c];
            t[i] = period_tick;
            @(negedge pwm_clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        enable       = 1'b0;
        cfg_load     = 1'b0;
        cfg_prescale = '0;
        cfg_period   = '0;
        cfg_center   = 1'b0;
        cfg_duty     = '0;
        cfg_pol      = '0;
        repeat (3) @(negedge pwm_clk);
        check_eq("rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("rst_tick", 32'(period_tick), 32'd0);
        check_eq("rst_pend", 32'(cfg_pending), 32'd0);
        rst = 1'b0;

        // 1: edge, period 9, duty 3 -> 3 high / 7 low, tick every 10
        load_cfg(8'd0, 8'd9, 1'b0, duties(0, 0, 0, 3), 4'b0000);
        check_eq("t1_pend", 32'(cfg_pending), 32'd0);
        enable = 1'b1;
        wait_tick("t1");
        capture(20, pw, tk);
        check_eq("t1_pwm", pw[0], 32'h0001C07);
        check_eq("t1_tick", tk, 32'h0000401);

        // 2: duty bounds with period 7, then inverted polarity
        enable = 1'b0;
        load_cfg(8'd0, 8'd7, 1'b0, duties(4, 511, 8, 0), 4'b0000);
        enable = 1'b1;
        wait_tick("t2a");
        capture(16, pw, tk);
        check_eq("t2_d0", pw[0], 32'h0000);
        check_eq("t2_d8", pw[1], 32'hFFFF);
        check_eq("t2_d511", pw[2], 32'hFFFF);
        check_eq("t2_d4", pw[3], 32'h0F0F);
        load_cfg(8'd0, 8'd7, 1'b0, duties(4, 511, 8, 0), 4'b1111);
        check_eq("t2_pend_set", 32'(cfg_pending), 32'd1);
        wait_tick("t2b");
        check_eq("t2_pend_clr", 32'(cfg_pending), 32'd0);
        capture(16, pw, tk);
        check_eq("t2_inv_d0", pw[0], 32'hFFFF);
        check_eq("t2_inv_d8", pw[1], 32'h0000);
        check_eq("t2_inv_d511", pw[2], 32'h0000);
        check_eq("t2_inv_d4", pw[3], 32'hF0F0);

        // 3: prescale 3, period 4, duty 2 -> 8 high / 12 low, tick every 20
        enable = 1'b0;
        load_cfg(8'd3, 8'd4, 1'b0, duties(0, 0, 0, 2), 4'b0000);
        enable = 1'b1;
        wait_tick("t3");
        capture(32, pw, tk);
        check_eq("t3_pwm", pw[0], 32'h0FF000FF);
        check_eq("t3_tick", tk, 32'h00100001);

        // 4: center, period 4, duty 2 -> counts 1,2,3,4,3,2,1,0 per period
        enable = 1'b0;
        load_cfg(8'd0, 8'd4, 1'b1, duties(0, 0, 0, 2), 4'b0000);
        enable = 1'b1;
        wait_tick("t4");
        capture(16, pw, tk);
        check_eq("t4_pwm", pw[0], 32'h0000C1C1);
        check_eq("t4_tick", tk, 32'h00000101);

        // 5: shadow - mid-period load (duty 6), then load on boundary (duty 2)
        enable = 1'b0;
        load_cfg(8'd0, 8'd9, 1'b0, duties(0, 0, 0, 3), 4'b0000);
        enable = 1'b1;
        wait_tick("t5");
        pw5 = '0;
        for (int i = 0; i < 24; i++) begin
            pw5[i] = pwm_out[0];
            if (i == 5)  check_eq("t5_pend_mid", 32'(cfg_pending), 32'd1);
            if (i == 10) check_eq("t5_pend_keep", 32'(cfg_pending), 32'd1);
            if (i == 20) check_eq("t5_pend_clr", 32'(cfg_pending), 32'd0);
            cfg_load = (i == 4) || (i == 8);
            if (i == 4) cfg_duty = duties(0, 0, 0, 6);
            if (i == 8) cfg_duty = duties(0, 0, 0, 2);
            @(negedge pwm_clk);
        end
        cfg_load = 1'b0;
        check_eq("t5_pwm", pw5, 32'h0030FC07);

        // 6: disabled idle level, immediate apply, reset mid-period
        enable = 1'b0;
        load_cfg(8'd0, 8'd9, 1'b0, duties(0, 0, 0, 3), 4'b1010);
        check_eq("t6_pend_dis", 32'(cfg_pending), 32'd0);
        @(negedge pwm_clk);
        check_eq("t6_idle", 32'(pwm_out), 32'hA);
        check_eq("t6_tick_dis", 32'(period_tick), 32'd0);
        enable = 1'b1;
        repeat (4) @(negedge pwm_clk);
        load_cfg(8'd0, 8'd5, 1'b0, duties(0, 0, 0, 1), 4'b0000);
        check_eq("t6_pend_pre", 32'(cfg_pending), 32'd1);
        rst = 1'b1;
        @(negedge pwm_clk);
        check_eq("t6_rst_pwm", 32'(pwm_out), 32'd0);
        check_eq("t6_rst_tick", 32'(period_tick), 32'd0);
        check_eq("t6_rst_pend", 32'(cfg_pending), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge pwm_clk);
        check_eq("t6_post_pwm", 32'(pwm_out), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
